// File: rtl/score_bcd_converter_if.sv
// rtl/score_bcd_converter_if.sv - score input and BCD display outputs of the score converter
//
// Ports (signals):
//   score_count  binary score from the pipe controller (master -> slave)
//   score_BCD    current score, {hundreds, tens, units} BCD nibbles
//   hiscore_BCD  highest converted score since reset, same format
//   busy         conversion in progress
//   valid        one-cycle strobe when score_BCD/hiscore_BCD have just updated
//   saturated    last converted score exceeded the display range
interface score_bcd_converter_if #(
    parameter int BIN_WIDTH = 32
);
    logic [BIN_WIDTH-1:0] score_count;
    logic [11:0]          score_BCD;
    logic [11:0]          hiscore_BCD;
    logic                 busy;
    logic                 valid;
    logic                 saturated;

    modport master (
        output score_count,
        input  score_BCD, hiscore_BCD, busy, valid, saturated
    );

    modport slave (
        input  score_count,
        output score_BCD, hiscore_BCD, busy, valid, saturated
    );
endinterface

// File: rtl/score_bcd_converter.sv
// rtl/score_bcd_converter.sv - sequential double-dabble score to BCD converter with hiscore tracking
//
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-low
//   bus  slave side of score_bcd_converter_if (score_count in; BCD words, busy, valid, saturated out)
module score_bcd_converter #(
    parameter int BIN_WIDTH = 32,
    parameter int CONV_BITS = 10,
    parameter int MAX_SCORE = 999
) (
    input  logic                  clk,
    input  logic                  rst,
    score_bcd_converter_if.slave  bus
);
    localparam int CNT_W = $clog2(CONV_BITS);
    localparam logic [BIN_WIDTH-1:0] MAX_BIN  = BIN_WIDTH'(MAX_SCORE);
    localparam logic [CONV_BITS-1:0] MAX_CONV = CONV_BITS'(MAX_SCORE);
    localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(CONV_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;

    logic [BIN_WIDTH-1:0] last_score;
    logic [CONV_BITS-1:0] bin_sh;
    logic [CONV_BITS-1:0] bin_val;      // clipped value of the conversion in flight
    logic [CONV_BITS-1:0] hiscore_bin;
    logic [11:0]          bcd_sh;
    logic [11:0]          bcd_adj;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 sat_flag;

    logic                 changed;
    logic                 over;
    logic [CONV_BITS-1:0] clipped;
    logic                 load;
    logic                 shift_en;
    logic                 done;

    assign changed = (bus.score_count != last_score);
    assign over    = (bus.score_count > MAX_BIN);
    assign clipped = over ? MAX_CONV : bus.score_count[CONV_BITS-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = changed ? SHIFT : IDLE;
            SHIFT:   next_state = (bit_cnt == LAST_BIT) ? DONE : SHIFT;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Per-state control decode
    always_comb begin
        load     = 1'b0;
        shift_en = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:    load     = changed;
            SHIFT:   shift_en = 1'b1;
            DONE:    done     = 1'b1;
            default: ;
        endcase
    end

    // Add-3 correction on every nibble that would overflow past 9 after doubling
    always_comb begin
        bcd_adj = bcd_sh;
        for (int i = 0; i < 3; i++) begin
            if (bcd_sh[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_sh[4*i +: 4] + 4'd3;
            end
        end
    end

    // Datapath and registered outputs; outputs only move in DONE so they never glitch mid-conversion
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_score      <= '0;
            bin_sh          <= '0;
            bin_val         <= '0;
            hiscore_bin     <= '0;
            bcd_sh          <= '0;
            bit_cnt         <= '0;
            sat_flag        <= 1'b0;
            bus.score_BCD   <= '0;
            bus.hiscore_BCD <= '0;
            bus.busy        <= 1'b0;
            bus.valid       <= 1'b0;
            bus.saturated   <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            bus.busy  <= (next_state != IDLE);

            if (load) begin
                last_score <= bus.score_count;
                bin_sh     <= clipped;
                bin_val    <= clipped;
                sat_flag   <= over;
                bcd_sh     <= '0;
                bit_cnt    <= '0;
            end

            if (shift_en) begin
                bcd_sh  <= {bcd_adj[10:0], bin_sh[CONV_BITS-1]};
                bin_sh  <= {bin_sh[CONV_BITS-2:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (done) begin
                bus.score_BCD <= bcd_sh;
                bus.saturated <= sat_flag;
                bus.valid     <= 1'b1;
                if (bin_val > hiscore_bin) begin
                    hiscore_bin     <= bin_val;
                    bus.hiscore_BCD <= bcd_sh;
                end
            end
        end
    end
endmodule

// File: tb/tb_score_bcd_converter.sv
// tb/tb_score_bcd_converter.sv - scoreboard bench for score_bcd_converter
module tb_score_bcd_converter;
    logic clk;
    logic rst;

    score_bcd_converter_if #(.BIN_WIDTH(32)) bus ();

    score_bcd_converter #(
        .BIN_WIDTH(32),
        .CONV_BITS(10),
        .MAX_SCORE(999)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct packed {
        logic [11:0] s;
        logic [11:0] h;
        logic        sat;
    } exp_t;

    exp_t sb[$];
    int   valid_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   valid_seen = 0;
    int   model_hi = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Sampling 1 time unit after each rising edge; main thread acts at +2
    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (bus.busy) busy_cnt++;
        if (bus.valid) begin
            valid_seen++;
            valid_cyc.push_back(cyc);
            chk("sb_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("score_BCD", 32'(bus.score_BCD), 32'(e.s));
                chk("hiscore_BCD", 32'(bus.hiscore_BCD), 32'(e.h));
                chk("saturated", 32'(bus.saturated), 32'(e.sat));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start_conv(input int v);
        int sv;
        exp_t e;
        sv = (v > 999) ? 999 : v;
        if (sv > model_hi) model_hi = sv;
        e.s   = to_bcd(sv);
        e.h   = to_bcd(model_hi);
        e.sat = (v > 999);
        sb.push_back(e);
        bus.score_count = 32'(v);
    endtask

    task automatic wait_valids(input int n, input string tag);
        int target;
        int budget;
        target = valid_seen + n;
        budget = 40 * n;
        while (valid_seen < target && budget > 0) begin
            step(1);
            budget--;
        end
        chk(tag, 32'(valid_seen >= target), 32'd1);
    endtask

    initial begin
        int v0;
        int k;
        int vals[4];

        rst = 1'b0;
        bus.score_count = '0;
        step(3);
        rst = 1'b1;

        // Idle with 0 held: nothing may happen
        step(100);
        chk("rst_score", 32'(bus.score_BCD), 32'h0);
        chk("rst_hiscore", 32'(bus.hiscore_BCD), 32'h0);
        chk("rst_saturated", 32'(bus.saturated), 32'h0);
        chk("idle_busy_cycles", 32'(busy_cnt), 32'd0);
        chk("idle_valid_pulses", 32'(valid_seen), 32'd0);

        // 0 -> 7: busy for 11 cycles, a single valid pulse
        busy_cnt = 0;
        v0 = valid_seen;
        start_conv(7);
        wait_valids(1, "timeout_7");
        step(5);
        chk("busy_len_7", 32'(busy_cnt), 32'd11);
        chk("valid_once_7", 32'(valid_seen - v0), 32'd1);
        chk("valid_dropped", 32'(bus.valid), 32'd0);

        // 123 then 45: hiscore keeps 123
        start_conv(123);
        wait_valids(1, "timeout_123");
        step(3);
        start_conv(45);
        wait_valids(1, "timeout_45");
        step(3);
        chk("hold_score_45", 32'(bus.score_BCD), 32'h045);

        // Saturation and recovery
        start_conv(1500);
        wait_valids(1, "timeout_1500");
        step(3);
        start_conv(3);
        wait_valids(1, "timeout_3");
        step(3);

        // Mid-conversion change: 10 at edge k, 11 at edge k+3
        valid_cyc.delete();
        k = cyc + 1;
        start_conv(10);
        step(3);
        start_conv(11);
        wait_valids(2, "timeout_retrigger");
        step(3);
        chk("first_valid_edge", 32'(valid_cyc.size() > 0 ? valid_cyc[0] : -1), 32'(k + 11));
        chk("second_valid_edge", 32'(valid_cyc.size() > 1 ? valid_cyc[1] : -1), 32'(k + 23));

        // Boundary values around the saturation point and a drop to 0
        vals = '{999, 998, 1000, 0};
        foreach (vals[i]) begin
            start_conv(vals[i]);
            wait_valids(1, "timeout_sweep");
            step(2);
        end

        // Reset at edge k+5 of a conversion of 200 aborts it
        v0 = valid_seen;
        bus.score_count = 32'd200;
        step(5);
        rst = 1'b0;
        step(3);
        chk("abort_score", 32'(bus.score_BCD), 32'h0);
        chk("abort_hiscore", 32'(bus.hiscore_BCD), 32'h0);
        chk("abort_saturated", 32'(bus.saturated), 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        chk("abort_no_valid", 32'(valid_seen - v0), 32'd0);
        rst = 1'b1;
        model_hi = 0;
        start_conv(200);
        wait_valids(1, "timeout_200");
        step(3);
        chk("post_reset_score", 32'(bus.score_BCD), 32'h200);

        step(20);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/score_bcd_converter.md
Name: score_bcd_converter

Overview:
- Sequential binary-to-BCD converter and hiscore tracker. Sits between the pipe controller's 32-bit score_count and the score display/renderer.
- Watches score_count and re-converts whenever it changes. Uses a shift-and-add-3 (double dabble) engine, one bit per clock.
- Presents stable 3-digit BCD score and hiscore words, plus a one-cycle valid strobe per update.

Parameters:
- BIN_WIDTH, 32, width of score_count input.
- CONV_BITS, 10, bits processed by the double-dabble engine; must hold MAX_SCORE.
- MAX_SCORE, 999, saturation value; larger inputs display as MAX_SCORE.

Ports:
- clk  in  1  system clock (50 MHz domain, same as pipe controller).
- rst  in  1  synchronous reset, active-low.
- score_count  in  BIN_WIDTH  current binary score from pipe controller.
- score_BCD  out  12  current score, {hundreds, tens, units} BCD nibbles.
- hiscore_BCD  out  12  highest converted score since reset, same format.
- busy  out  1  high while a conversion is in progress.
- valid  out  1  one-cycle pulse when score_BCD/hiscore_BCD have just updated.
- saturated  out  1  high when the last converted score_count exceeded MAX_SCORE.

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE; score_BCD, hiscore_BCD, busy, valid, saturated = 0; internal last_score=0, hiscore_bin=0, shift/BCD registers cleared. Reset mid-conversion aborts it with no output update.
- States: IDLE, SHIFT, DONE.
- IDLE, score_count != last_score:
  - last_score <= score_count.
  - Load bin_sh <= min(score_count, MAX_SCORE) in CONV_BITS bits; sat_flag <= (score_count > MAX_SCORE).
  - bcd_sh <= 0, bit_cnt <= 0, go to SHIFT.
- IDLE, score_count == last_score: stay in IDLE.
- SHIFT, each cycle:
  - For each BCD nibble >= 5, add 3 (combinational on current bcd_sh).
  - Shift {bcd_sh, bin_sh} left by 1 (MSB of bin_sh enters units LSB).
  - bit_cnt++. When bit_cnt reaches CONV_BITS-1 on this edge (i.e. after CONV_BITS shifts), go to DONE.
- DONE, one cycle:
  - score_BCD <= bcd_sh; saturated <= sat_flag; valid <= 1; go to IDLE.
  - If the saturated binary value > hiscore_bin: hiscore_bin <= value and hiscore_BCD <= bcd_sh (same edge as score_BCD). Equal or lower leaves the hiscore unchanged.
- Latency: change sampled at edge k → SHIFT edges k+1..k+10 → outputs update at edge k+11; valid high for exactly one cycle after edge k+11.
- busy: registered; high from edge k to edge k+11, i.e. whenever state != IDLE.
- valid: cleared every cycle it is not being set.
- score_count changes during SHIFT/DONE are ignored, but last_score holds the old value. The first IDLE cycle therefore re-triggers a conversion, so outputs always converge to the latest input.
  - Back-to-back changes produce back-to-back conversions with exactly one IDLE cycle between them.
- Score drop (new game, score_count→0) converts normally; the hiscore is retained. Only rst clears the hiscore.
- Widths: bcd_sh is 12 bits; add-3 is applied per 4-bit nibble. No BCD nibble may ever exceed 9 at output.
- Outputs hold their values between conversions; they never glitch mid-conversion.

Test Plan:
- Reset with score_count=0 held: all outputs 0, busy never asserts, valid never pulses over 100 cycles.
- Step score_count 0→7: busy high 11 cycles; at edge k+11 score_BCD=12'h007, hiscore_BCD=12'h007, valid single pulse, saturated=0.
- Sequence 123 → (wait) → 45:
  - After first conversion: score_BCD=12'h123, hiscore_BCD=12'h123.
  - After second: score_BCD=12'h045, hiscore_BCD stays 12'h123.
- score_count=1500: score_BCD=12'h999, saturated=1, hiscore_BCD=12'h999. Then score_count=3: score_BCD=12'h003, saturated=0.
- score_count 10 at edge k, then 11 at edge k+3 (mid-conversion):
  - First valid with 12'h010 at k+11.
  - Retrigger at k+12; second valid with 12'h011 at k+23.
- Assert rst=0 at edge k+5 of a conversion of 200: no valid pulse; all outputs 0 after reset. With 200 still on the input after release, a fresh conversion completes with 12'h200.
